// File: rtl/control_burbujas.sv
// control_burbujas: stall/bubble sequencer for the filter processor pipe.
// Inserts LOAD_LAT NOP bubbles per load-use hazard and freezes the whole
// pipe while data memory is busy. A MAX_WAIT guard forces the pipe to
// release and raises a sticky flag.
//
// Memory handshake: the MEM stage raises mem_req for every cycle its
// instruction accesses data memory. The access completes in the cycle where
// mem_req and mem_ready are both 1. A cycle with mem_req=1 and mem_ready=0
// is a freeze cycle. Once the sequencer is waiting on memory, only
// mem_ready (or the timeout) ends the wait, and mem_req is no longer looked at.
module control_burbujas #(
    parameter int LOAD_LAT = 1,
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_req,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             PC_EN,
    output logic             F_Reg_EN,
    output logic             D_Reg_EN,
    output logic             E_Reg_EN,
    output logic             NOP_Mux,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic             busy
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BUBBLE  = 2'd1,
        MEMWAIT = 2'd2
    } state_t;

    localparam logic [3:0] BUB_INIT = 4'(LOAD_LAT - 1);
    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] bub_cnt;
    logic [3:0] bub_cnt_nxt;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_nxt;
    logic       timeout_set;
    logic       freeze;

    assign freeze = mem_req & ~mem_ready;

    // The reset term keeps busy low during the reset cycle, even while the
    // state register still holds an older value.
    assign busy = ~rst & (state != RUN);

    // State and counter registers. The stall counter saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            bub_cnt     <= 4'd0;
            wait_cnt    <= 8'd0;
            mem_timeout <= 1'b0;
            stall_count <= '0;
        end else begin
            state    <= state_nxt;
            bub_cnt  <= bub_cnt_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (timeout_set) begin
                mem_timeout <= 1'b1;
            end
            if (!PC_EN && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

    // Mealy enables and next state. A memory freeze outranks a bubble, and a bubble outranks a normal advance.
    always_comb begin
        PC_EN        = 1'b1;
        F_Reg_EN     = 1'b1;
        D_Reg_EN     = 1'b1;
        E_Reg_EN     = 1'b1;
        NOP_Mux      = 1'b0;
        state_nxt    = state;
        bub_cnt_nxt  = bub_cnt;
        wait_cnt_nxt = wait_cnt;
        timeout_set  = 1'b0;

        if (rst) begin
            // Flush: hold the front end and push NOPs down the back end.
            PC_EN    = 1'b0;
            F_Reg_EN = 1'b0;
            NOP_Mux  = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (freeze) begin
                        // The hazard stays asserted while ID is frozen, so it is
                        // handled after the freeze ends.
                        PC_EN        = 1'b0;
                        F_Reg_EN     = 1'b0;
                        D_Reg_EN     = 1'b0;
                        E_Reg_EN     = 1'b0;
                        wait_cnt_nxt = 8'd1;
                        state_nxt    = MEMWAIT;
                    end else if (hazard_req) begin
                        PC_EN    = 1'b0;
                        F_Reg_EN = 1'b0;
                        NOP_Mux  = 1'b1;
                        if (LOAD_LAT > 1) begin
                            bub_cnt_nxt = BUB_INIT;
                            state_nxt   = BUBBLE;
                        end
                    end
                end
                BUBBLE: begin
                    if (freeze) begin
                        // Pause the bubble sequence. The bubble count is held.
                        PC_EN    = 1'b0;
                        F_Reg_EN = 1'b0;
                        D_Reg_EN = 1'b0;
                        E_Reg_EN = 1'b0;
                    end else begin
                        PC_EN       = 1'b0;
                        F_Reg_EN    = 1'b0;
                        NOP_Mux     = 1'b1;
                        bub_cnt_nxt = bub_cnt - 4'd1;
                        if (bub_cnt == 4'd1) begin
                            state_nxt = RUN;
                        end
                    end
                end
                MEMWAIT: begin
                    if (mem_ready) begin
                        state_nxt    = RUN;
                        wait_cnt_nxt = 8'd0;
                    end else if (wait_cnt == WAIT_MAX) begin
                        // Forced release. The pipe advances as if memory had answered.
                        timeout_set  = 1'b1;
                        state_nxt    = RUN;
                        wait_cnt_nxt = 8'd0;
                    end else begin
                        PC_EN        = 1'b0;
                        F_Reg_EN     = 1'b0;
                        D_Reg_EN     = 1'b0;
                        E_Reg_EN     = 1'b0;
                        wait_cnt_nxt = wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_burbujas.sv
// Bench for control_burbujas. Two instances share one stimulus stream:
// instance 0 has LOAD_LAT=1 with a 16-bit counter, and instance 1 has
// LOAD_LAT=3 with a 4-bit counter so that saturation is reachable.
// A cycle-level reference model tracks owed bubbles and the memory wait.
module tb_control_burbujas;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int MW    = 8;

    logic clk;
    logic rst;
    logic hazard_req;
    logic mem_req;
    logic mem_ready;

    logic        pc_a, f_a, d_a, e_a, nop_a, tmo_a, busy_a;
    logic        pc_b, f_b, d_b, e_b, nop_b, tmo_b, busy_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    // Observed vectors are {PC_EN, F, D, E, NOP_Mux, busy, mem_timeout}.
    logic [6:0]  obs_vec [2];
    logic [15:0] obs_cnt [2];

    int n_tests;
    int n_fail;

    // Model state. m_* is the current value and n_* the value after the next edge.
    int   m_owed [2];
    int   m_wcnt [2];
    int   m_scnt [2];
    bit   m_wait [2];
    bit   m_tmo  [2];
    int   n_owed [2];
    int   n_wcnt [2];
    int   n_scnt [2];
    bit   n_wait [2];
    bit   n_tmo  [2];
    logic [6:0]  exp_vec [2];
    logic [15:0] exp_cnt [2];

    control_burbujas #(.LOAD_LAT(LAT_A), .MAX_WAIT(MW), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .hazard_req(hazard_req), .mem_req(mem_req),
        .mem_ready(mem_ready), .PC_EN(pc_a), .F_Reg_EN(f_a), .D_Reg_EN(d_a),
        .E_Reg_EN(e_a), .NOP_Mux(nop_a), .mem_timeout(tmo_a),
        .stall_count(cnt_a), .busy(busy_a)
    );

    control_burbujas #(.LOAD_LAT(LAT_B), .MAX_WAIT(MW), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .hazard_req(hazard_req), .mem_req(mem_req),
        .mem_ready(mem_ready), .PC_EN(pc_b), .F_Reg_EN(f_b), .D_Reg_EN(d_b),
        .E_Reg_EN(e_b), .NOP_Mux(nop_b), .mem_timeout(tmo_b),
        .stall_count(cnt_b), .busy(busy_b)
    );

    assign obs_vec[0] = {pc_a, f_a, d_a, e_a, nop_a, busy_a, tmo_a};
    assign obs_vec[1] = {pc_b, f_b, d_b, e_b, nop_b, busy_b, tmo_b};
    assign obs_cnt[0] = cnt_a;
    assign obs_cnt[1] = {12'd0, cnt_b};

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model for one cycle, evaluated from the rules in terms of
    // "bubbles still owed" and "waiting on memory for N cycles".
    task automatic model_eval();
        for (int k = 0; k < 2; k++) begin
            int         lat;
            int         cmax;
            logic [4:0] en;
            logic       bsy;
            lat       = (k == 0) ? LAT_A : LAT_B;
            cmax      = (k == 0) ? 65535 : 15;
            n_owed[k] = m_owed[k];
            n_wcnt[k] = m_wcnt[k];
            n_scnt[k] = m_scnt[k];
            n_wait[k] = m_wait[k];
            n_tmo[k]  = m_tmo[k];
            if (rst) begin
                en        = 5'b00111;
                bsy       = 1'b0;
                n_owed[k] = 0;
                n_wcnt[k] = 0;
                n_scnt[k] = 0;
                n_wait[k] = 1'b0;
                n_tmo[k]  = 1'b0;
            end else begin
                bsy = m_wait[k] || (m_owed[k] > 0);
                if (m_wait[k]) begin
                    if (mem_ready || m_wcnt[k] == MW) begin
                        en        = 5'b11110;
                        n_wait[k] = 1'b0;
                        n_wcnt[k] = 0;
                        if (!mem_ready) n_tmo[k] = 1'b1;
                    end else begin
                        en        = 5'b00000;
                        n_wcnt[k] = m_wcnt[k] + 1;
                    end
                end else if (mem_req && !mem_ready) begin
                    en = 5'b00000;
                    if (m_owed[k] == 0) begin
                        n_wait[k] = 1'b1;
                        n_wcnt[k] = 1;
                    end
                end else if (m_owed[k] > 0) begin
                    en        = 5'b00111;
                    n_owed[k] = m_owed[k] - 1;
                end else if (hazard_req) begin
                    en        = 5'b00111;
                    n_owed[k] = lat - 1;
                end else begin
                    en = 5'b11110;
                end
                if (!en[4] && m_scnt[k] < cmax) n_scnt[k] = m_scnt[k] + 1;
            end
            exp_vec[k] = {en, bsy, m_tmo[k]};
            exp_cnt[k] = 16'(m_scnt[k]);
        end
    endtask

    // Driver: advance one clock edge, drive this cycle's inputs and refresh the model expectations.
    task automatic apply(input logic r, input logic hz, input logic mq, input logic mr);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            m_owed[k] = n_owed[k];
            m_wcnt[k] = n_wcnt[k];
            m_scnt[k] = n_scnt[k];
            m_wait[k] = n_wait[k];
            m_tmo[k]  = n_tmo[k];
        end
        #2;
        rst        = r;
        hazard_req = hz;
        mem_req    = mq;
        mem_ready  = mr;
        model_eval();
        #1;
    endtask

    task automatic test_reset();
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (obs_vec[k][6:1] !== exp_vec[k][6:1]) begin
                n_fail++;
                $display("FAIL reset_first dut%0d got=%b exp=%b", k, obs_vec[k][6:1], exp_vec[k][6:1]);
            end
        end
        apply(1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (obs_vec[k] !== 7'b0011100 || obs_cnt[k] !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_hold dut%0d got=%b cnt=%0d exp=0011100 cnt=0", k, obs_vec[k], obs_cnt[k]);
            end
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (obs_vec[k] !== 7'b1111000 || obs_cnt[k] !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_idle dut%0d got=%b cnt=%0d exp=1111000 cnt=0", k, obs_vec[k], obs_cnt[k]);
            end
        end
    endtask

    task automatic test_hazard_lat1();
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (obs_vec[0] !== 7'b0011100) begin
            n_fail++;
            $display("FAIL hazard1_stall got=%b exp=0011100", obs_vec[0]);
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (obs_vec[0] !== 7'b1111000 || obs_cnt[0] !== 16'd1) begin
            n_fail++;
            $display("FAIL hazard1_after got=%b cnt=%0d exp=1111000 cnt=1", obs_vec[0], obs_cnt[0]);
        end
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (obs_vec[k] !== exp_vec[k] || obs_cnt[k] !== exp_cnt[k]) begin
                n_fail++;
                $display("FAIL hazard1_model dut%0d got=%b/%0d exp=%b/%0d", k, obs_vec[k], obs_cnt[k], exp_vec[k], exp_cnt[k]);
            end
        end
    endtask

    task automatic test_hazard_lat3();
        int nops;
        int busies;
        nops   = 0;
        busies = 0;
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            apply(1'b0, (c == 1), 1'b0, 1'b0);
            if (nop_b === 1'b1 && pc_b === 1'b0) nops++;
            if (busy_b === 1'b1) busies++;
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (obs_vec[k] !== exp_vec[k] || obs_cnt[k] !== exp_cnt[k]) begin
                    n_fail++;
                    $display("FAIL hazard3_model c=%0d dut%0d got=%b/%0d exp=%b/%0d", c, k, obs_vec[k], obs_cnt[k], exp_vec[k], exp_cnt[k]);
                end
            end
        end
        n_tests++;
        if (nops !== 3 || busies !== 2 || obs_cnt[1] !== 16'd3) begin
            n_fail++;
            $display("FAIL hazard3_totals nops=%0d busy=%0d cnt=%0d exp 3 2 3", nops, busies, obs_cnt[1]);
        end
    endtask

    task automatic test_memwait();
        int frozen;
        frozen = 0;
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            apply(1'b0, 1'b0, (c <= 5), (c == 5));
            if (c <= 5 && obs_vec[0][6:3] === 4'b0000) frozen++;
            if (c == 5) begin
                n_tests++;
                if (obs_vec[0][6:2] !== 5'b11110) begin
                    n_fail++;
                    $display("FAIL memwait_release got=%b exp=11110", obs_vec[0][6:2]);
                end
            end
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (obs_vec[k] !== exp_vec[k] || obs_cnt[k] !== exp_cnt[k]) begin
                    n_fail++;
                    $display("FAIL memwait_model c=%0d dut%0d got=%b/%0d exp=%b/%0d", c, k, obs_vec[k], obs_cnt[k], exp_vec[k], exp_cnt[k]);
                end
            end
        end
        n_tests++;
        if (frozen !== 4 || obs_cnt[0] !== 16'd4 || busy_a !== 1'b0 || tmo_a !== 1'b0) begin
            n_fail++;
            $display("FAIL memwait_totals frozen=%0d cnt=%0d busy=%b tmo=%b exp 4 4 0 0", frozen, obs_cnt[0], busy_a, tmo_a);
        end
    endtask

    task automatic test_timeout();
        int frozen;
        frozen = 0;
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            apply(1'b0, 1'b0, 1'b1, 1'b0);
            if (obs_vec[0][6:3] === 4'b0000) frozen++;
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (obs_vec[k] !== exp_vec[k] || obs_cnt[k] !== exp_cnt[k]) begin
                    n_fail++;
                    $display("FAIL timeout_model c=%0d dut%0d got=%b/%0d exp=%b/%0d", c, k, obs_vec[k], obs_cnt[k], exp_vec[k], exp_cnt[k]);
                end
            end
        end
        n_tests++;
        if (frozen !== 8 || obs_vec[0][6:3] !== 4'b1111 || tmo_a !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_release frozen=%0d en=%b tmo=%b exp 8 1111 0", frozen, obs_vec[0][6:3], tmo_a);
        end
        for (int c = 0; c < 5; c++) apply(1'b0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (tmo_a !== 1'b1 || tmo_b !== 1'b1 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_sticky tmo=%b%b busy=%b exp 11 0", tmo_a, tmo_b, busy_a);
        end
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (tmo_a !== 1'b0 || tmo_b !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear tmo=%b%b exp 00", tmo_a, tmo_b);
        end
    endtask

    task automatic test_bubble_freeze();
        int nops;
        int frozen;
        nops   = 0;
        frozen = 0;
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            apply(1'b0, (c == 1), (c == 2 || c == 3), (c == 4));
            if (nop_b === 1'b1) nops++;
            if (obs_vec[1][6:2] === 5'b00000) frozen++;
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (obs_vec[k] !== exp_vec[k] || obs_cnt[k] !== exp_cnt[k]) begin
                    n_fail++;
                    $display("FAIL bubfrz_model c=%0d dut%0d got=%b/%0d exp=%b/%0d", c, k, obs_vec[k], obs_cnt[k], exp_vec[k], exp_cnt[k]);
                end
            end
        end
        n_tests++;
        if (nops !== 3 || frozen !== 2 || obs_cnt[1] !== 16'd5) begin
            n_fail++;
            $display("FAIL bubfrz_totals nops=%0d frozen=%0d cnt=%0d exp 3 2 5", nops, frozen, obs_cnt[1]);
        end
    endtask

    task automatic test_reset_mid();
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        apply(1'b1, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (obs_vec[0] !== 7'b0011100) begin
            n_fail++;
            $display("FAIL rstmid_flush got=%b exp=0011100", obs_vec[0]);
        end
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (obs_vec[0] !== 7'b0011100 || obs_cnt[0] !== 16'd0) begin
            n_fail++;
            $display("FAIL rstmid_hazard got=%b cnt=%0d exp=0011100 cnt=0", obs_vec[0], obs_cnt[0]);
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (obs_vec[0] !== 7'b1111000 || obs_cnt[0] !== 16'd1) begin
            n_fail++;
            $display("FAIL rstmid_after got=%b cnt=%0d exp=1111000 cnt=1", obs_vec[0], obs_cnt[0]);
        end
    endtask

    task automatic test_saturate();
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 20; c++) apply(1'b0, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (obs_cnt[1] !== 16'd15 || obs_cnt[0] !== 16'd20) begin
            n_fail++;
            $display("FAIL saturate cnt_b=%0d cnt_a=%0d exp 15 20", obs_cnt[1], obs_cnt[0]);
        end
    endtask

    task automatic test_random();
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 600; c++) begin
            apply(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (obs_vec[k] !== exp_vec[k] || obs_cnt[k] !== exp_cnt[k]) begin
                    n_fail++;
                    $display("FAIL random c=%0d dut%0d got=%b/%0d exp=%b/%0d", c, k, obs_vec[k], obs_cnt[k], exp_vec[k], exp_cnt[k]);
                end
            end
        end
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        hazard_req = 1'b0;
        mem_req    = 1'b0;
        mem_ready  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_owed[k] = 0; m_wcnt[k] = 0; m_scnt[k] = 0; m_wait[k] = 1'b0; m_tmo[k] = 1'b0;
            n_owed[k] = 0; n_wcnt[k] = 0; n_scnt[k] = 0; n_wait[k] = 1'b0; n_tmo[k] = 1'b0;
        end
        test_reset();
        test_hazard_lat1();
        test_hazard_lat3();
        test_memwait();
        test_timeout();
        test_bubble_freeze();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
